// File: rtl/star_spawn_if.sv
// Spawn offer channel between the star spawn scheduler (master) and the object/draw logic (slave).
// Handshake: spawn_valid rises with slot/x already stable and holds them until a cycle with
// spawn_ready=1 (that cycle is the transfer); valid is never withdrawn before that transfer.
interface star_spawn_if #(
  parameter int SLOT_BITS = 3,
  parameter int X_BITS    = 10
);
  logic                 spawn_valid;
  logic                 spawn_ready;
  logic [SLOT_BITS-1:0] spawn_slot;
  logic [X_BITS-1:0]    spawn_x;

  modport master (output spawn_valid, output spawn_slot, output spawn_x, input spawn_ready);
  modport slave  (input spawn_valid, input spawn_slot, input spawn_x, output spawn_ready);
endinterface

// File: rtl/star_spawn_scheduler.sv
// Star spawn scheduler: counts spawn ticks, allocates the lowest free sprite slot and offers one spawn
// at a time with an LFSR-derived X. Optional counters spawn_count/drop_count under SPAWN_STATS_EN.
module star_spawn_scheduler #(
  parameter int NUM_SLOTS = 8,
  parameter int SLOT_BITS = 3,
  parameter int PEND_BITS = 3,
  parameter int COOLDOWN  = 4,
  parameter int X_BITS    = 10,
  parameter int X_MAX     = 619
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 enable,
  input  logic                 tick,
  input  logic [NUM_SLOTS-1:0] release_mask,
  star_spawn_if.master         spawn,
  output logic [NUM_SLOTS-1:0] busy_mask,
  output logic [PEND_BITS-1:0] pending_cnt,
  output logic                 overflow,
  output logic [1:0]           state_dbg
`ifdef SPAWN_STATS_EN
  ,
  output logic [15:0]          spawn_count,
  output logic [7:0]           drop_count
`endif
);

  localparam int CW = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);
  localparam logic [PEND_BITS-1:0] PEND_MAX = '1;
  localparam logic [X_BITS-1:0]    X_LIMIT  = X_BITS'(X_MAX);
  localparam logic [X_BITS-1:0]    X_SPAN   = X_BITS'(X_MAX + 1);
  localparam logic [NUM_SLOTS-1:0] SLOT_ONE = NUM_SLOTS'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_COOL  = 2'd2
  } state_t;

  state_t               state;
  logic [15:0]          lfsr;
  logic [15:0]          lfsr_next;
  logic [CW-1:0]        cool_cnt;
  logic                 valid_q;
  logic [SLOT_BITS-1:0] slot_q;
  logic [X_BITS-1:0]    x_q;
  logic [X_BITS-1:0]    lfsr_r;
  logic [X_BITS-1:0]    x_new;
  logic [SLOT_BITS-1:0] free_idx;
  logic                 any_free;
  logic                 accept;

  assign accept            = valid_q & spawn.spawn_ready;
  assign spawn.spawn_valid = valid_q;
  assign spawn.spawn_slot  = slot_q;
  assign spawn.spawn_x     = x_q;
  assign state_dbg         = state;

  // Galois form of x^16+x^14+x^13+x^11+1; a nonzero seed never reaches zero.
  assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  assign lfsr_r    = lfsr[X_BITS-1:0];
  assign x_new     = (lfsr_r <= X_LIMIT) ? lfsr_r : (lfsr_r - X_SPAN);

  always_comb begin
    free_idx = '0;
    any_free = 1'b0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!busy_mask[i]) begin
        free_idx = SLOT_BITS'(i);
        any_free = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) lfsr <= 16'hACE1;
    else         lfsr <= lfsr_next;
  end

  // A tick and an accept in the same cycle cancel; a dropped tick is flagged for one cycle.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pending_cnt <= '0;
      overflow    <= 1'b0;
    end else if (!enable) begin
      pending_cnt <= '0;
      overflow    <= 1'b0;
    end else begin
      overflow <= 1'b0;
      if (tick && !accept) begin
        if (pending_cnt == PEND_MAX) overflow    <= 1'b1;
        else                         pending_cnt <= pending_cnt + PEND_BITS'(1);
      end else if (accept && !tick && pending_cnt != '0) begin
        pending_cnt <= pending_cnt - PEND_BITS'(1);
      end
    end
  end

  // Releases clear first, so an accept of the same slot in the same cycle leaves it busy.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) busy_mask <= '0;
    else         busy_mask <= (busy_mask & ~release_mask) | (accept ? (SLOT_ONE << slot_q) : '0);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state    <= S_IDLE;
      valid_q  <= 1'b0;
      slot_q   <= '0;
      x_q      <= '0;
      cool_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (enable && pending_cnt != '0 && any_free) begin
            state   <= S_ISSUE;
            valid_q <= 1'b1;
            slot_q  <= free_idx;
            x_q     <= x_new;
          end
        end
        S_ISSUE: begin
          if (spawn.spawn_ready) begin
            valid_q <= 1'b0;
            if (COOLDOWN == 0) begin
              state <= S_IDLE;
            end else begin
              state    <= S_COOL;
              cool_cnt <= CW'(COOLDOWN);
            end
          end
        end
        S_COOL: begin
          cool_cnt <= cool_cnt - CW'(1);
          if (cool_cnt == CW'(1)) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SPAWN_STATS_EN
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      spawn_count <= '0;
      drop_count  <= '0;
    end else begin
      if (accept) spawn_count <= spawn_count + 16'd1;
      if (overflow && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_star_spawn_scheduler.sv
// Bench for star_spawn_scheduler: directed steps from the test plan, then randomized traffic
// checked cycle by cycle against a transaction-level reference of the scheduling rules.
module tb_star_spawn_scheduler;
  localparam int NS = 8;
  localparam int SB = 3;
  localparam int PB = 3;
  localparam int CD = 4;
  localparam int XB = 10;
  localparam int XM = 619;

  logic          clk = 1'b0;
  logic          resetN = 1'b0;
  logic          enable = 1'b0;
  logic          tick = 1'b0;
  logic [NS-1:0] release_mask = '0;
  logic [NS-1:0] busy_mask;
  logic [PB-1:0] pending_cnt;
  logic          overflow;
  logic [1:0]    state_dbg;
`ifdef SPAWN_STATS_EN
  logic [15:0]   spawn_count;
  logic [7:0]    drop_count;
`endif

  star_spawn_if #(.SLOT_BITS(SB), .X_BITS(XB)) sp ();

  star_spawn_scheduler #(
    .NUM_SLOTS(NS), .SLOT_BITS(SB), .PEND_BITS(PB),
    .COOLDOWN(CD), .X_BITS(XB), .X_MAX(XM)
  ) dut (
    .clk(clk),
    .resetN(resetN),
    .enable(enable),
    .tick(tick),
    .release_mask(release_mask),
    .spawn(sp),
    .busy_mask(busy_mask),
    .pending_cnt(pending_cnt),
    .overflow(overflow),
    .state_dbg(state_dbg)
`ifdef SPAWN_STATS_EN
    ,
    .spawn_count(spawn_count),
    .drop_count(drop_count)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  // ---------------- reference helpers ----------------
  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] lfsr_m;
  logic [15:0] lfsr_prev;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    logic [15:0] n;
    n = l >> 1;
    if (l[0]) n = n ^ 16'hB400;
    return n;
  endfunction

  // Free-running LFSR copy; lfsr_prev is the value the DUT saw during the previous cycle.
  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      lfsr_m    <= 16'hACE1;
      lfsr_prev <= 16'hACE1;
    end else begin
      lfsr_prev <= lfsr_m;
      lfsr_m    <= lfsr_step(lfsr_m);
    end
  end

  function automatic int xf(input logic [15:0] l);
    int r;
    r = int'(l) % (1 << XB);
    return (r <= XM) ? r : r - (XM + 1);
  endfunction

  function automatic int lowest_free(input logic [NS-1:0] b);
    for (int i = 0; i < NS; i++) if (!b[i]) return i;
    return 0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard state ----------------
  int          k;
  int          last_rise;
  int          x_exp;
  int          e;
  int          m_last_acc;
  int          m_slot;
  int          m_x;
  int          m_pend;
  int          p_pre;
  int          n_acc;
  int          n_ovf;
  logic        m_valid;
  logic        m_ovf;
  logic        v_pre;
  logic        acc;
  logic        rise;
  logic [NS-1:0] m_busy;
  logic [NS-1:0] b_pre;

  initial begin
    sp.spawn_ready = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", sp.spawn_valid, 0);
    chk("rst_slot", sp.spawn_slot, 0);
    chk("rst_x", sp.spawn_x, 0);
    chk("rst_busy", busy_mask, 0);
    chk("rst_pend", pending_cnt, 0);
    chk("rst_ovf", overflow, 0);
    #3 resetN = 1'b1;

    // single tick: pending at t+1, offer at t+2, slot busy after accept
    enable = 1'b1;
    sp.spawn_ready = 1'b1;
    repeat (9) cyc();
    tick = 1'b1;
    cyc();
    chk("t1_pend", pending_cnt, 1);
    chk("t1_novalid", sp.spawn_valid, 0);
    tick = 1'b0;
    cyc();
    chk("t1_valid", sp.spawn_valid, 1);
    chk("t1_slot", sp.spawn_slot, 0);
    chk("t1_x_range", (sp.spawn_x <= XM), 1);
    chk("t1_x", sp.spawn_x, xf(lfsr_prev));
    cyc();
    chk("t1_valid_off", sp.spawn_valid, 0);
    chk("t1_busy", busy_mask, 8'h01);
    chk("t1_pend0", pending_cnt, 0);
    release_mask = 8'h01;
    cyc();
    release_mask = '0;
    chk("t1_release", busy_mask, 8'h00);
    repeat (5) cyc();

    // eight ticks back to back: slots in order, COOLDOWN+2 spacing
    k = 0;
    last_rise = -1;
    for (int i = 0; i < 60; i++) begin
      tick = (i < 8);
      cyc();
      if (sp.spawn_valid) begin
        chk("t2_slot", sp.spawn_slot, k);
        chk("t2_x", sp.spawn_x, xf(lfsr_prev));
        if (k == 0) chk("t2_first_lat", i, 1);
        else        chk("t2_spacing", i - last_rise, CD + 2);
        last_rise = i;
        k++;
      end
    end
    chk("t2_count", k, 8);
    chk("t2_busy", busy_mask, 8'hFF);
    chk("t2_pend", pending_cnt, 0);

    // pool full: ticks wait until a release frees slot 5
    tick = 1'b1;
    repeat (3) cyc();
    tick = 1'b0;
    repeat (4) cyc();
    chk("t3_pend", pending_cnt, 3);
    chk("t3_novalid", sp.spawn_valid, 0);
    release_mask = 8'h20;
    cyc();
    release_mask = '0;
    chk("t3_busy_rel", busy_mask, 8'hDF);
    chk("t3_novalid2", sp.spawn_valid, 0);
    cyc();
    chk("t3_valid", sp.spawn_valid, 1);
    chk("t3_slot", sp.spawn_slot, 5);
    chk("t3_x", sp.spawn_x, xf(lfsr_prev));
    cyc();
    chk("t3_busy", busy_mask, 8'hFF);
    chk("t3_pend2", pending_cnt, 2);
    chk("t3_valid_off", sp.spawn_valid, 0);

    // saturation: 9 ticks, overflow on the 8th and 9th
    enable = 1'b0;
    cyc();
    chk("t4_flush", pending_cnt, 0);
    enable = 1'b1;
    for (int t = 1; t <= 9; t++) begin
      tick = 1'b1;
      cyc();
      chk("t4_pend", pending_cnt, (t < 7) ? t : 7);
      chk("t4_ovf", overflow, (t >= 8));
    end
    tick = 1'b0;
    cyc();
    chk("t4_ovf_end", overflow, 0);
    chk("t4_pend_end", pending_cnt, 7);

    // stalled offer holds; accept and release of the same slot leaves it busy
    sp.spawn_ready = 1'b0;
    release_mask = 8'h08;
    cyc();
    release_mask = '0;
    cyc();
    chk("t5_valid", sp.spawn_valid, 1);
    chk("t5_slot", sp.spawn_slot, 3);
    x_exp = xf(lfsr_prev);
    chk("t5_x", sp.spawn_x, x_exp);
    for (int t = 0; t < 10; t++) begin
      cyc();
      chk("t5_hold_valid", sp.spawn_valid, 1);
      chk("t5_hold_slot", sp.spawn_slot, 3);
      chk("t5_hold_x", sp.spawn_x, x_exp);
    end
    sp.spawn_ready = 1'b1;
    release_mask = 8'h08;
    cyc();
    release_mask = '0;
    chk("t5_busy", busy_mask, 8'hFF);
    chk("t5_valid_off", sp.spawn_valid, 0);
    chk("t5_pend", pending_cnt, 6);

    // enable drop flushes the count but not the offer in flight
    repeat (6) cyc();
    enable = 1'b0;
    cyc();
    chk("t6_flush", pending_cnt, 0);
    enable = 1'b1;
    sp.spawn_ready = 1'b0;
    release_mask = 8'h04;
    tick = 1'b1;
    cyc();
    release_mask = '0;
    chk("t6_busy", busy_mask, 8'hFB);
    chk("t6_pend1", pending_cnt, 1);
    repeat (3) cyc();
    chk("t6_pend4", pending_cnt, 4);
    chk("t6_valid", sp.spawn_valid, 1);
    chk("t6_slot", sp.spawn_slot, 2);
    tick = 1'b0;
    enable = 1'b0;
    cyc();
    chk("t6_pend_drop", pending_cnt, 0);
    chk("t6_valid_kept", sp.spawn_valid, 1);
    enable = 1'b1;
    sp.spawn_ready = 1'b1;
    cyc();
    chk("t6_valid_off", sp.spawn_valid, 0);
    chk("t6_busy_full", busy_mask, 8'hFF);
    chk("t6_pend_acc", pending_cnt, 0);
    cyc();
    chk("t6_pend_stay", pending_cnt, 0);

    // asynchronous reset in the middle of activity
    tick = 1'b1;
    repeat (3) cyc();
    tick = 1'b0;
    #3 resetN = 1'b0;
    #1;
    chk("mr_valid", sp.spawn_valid, 0);
    chk("mr_slot", sp.spawn_slot, 0);
    chk("mr_x", sp.spawn_x, 0);
    chk("mr_busy", busy_mask, 0);
    chk("mr_pend", pending_cnt, 0);
    chk("mr_ovf", overflow, 0);
    #3 resetN = 1'b1;

    // randomized traffic against the reference
    m_valid = 1'b0; m_ovf = 1'b0; m_busy = '0; m_pend = 0;
    m_slot = 0; m_x = 0; m_last_acc = -1000; e = 0; n_acc = 0; n_ovf = 0;
    for (int i = 0; i < 3000; i++) begin
      enable         = ($urandom_range(0, 49) != 0);
      tick           = ($urandom_range(0, 2) == 0);
      release_mask   = ($urandom_range(0, 5) == 0) ? NS'($urandom) : '0;
      sp.spawn_ready = 1'($urandom_range(0, 1));
      v_pre = m_valid;
      b_pre = m_busy;
      p_pre = m_pend;
      cyc();
      e++;
      acc = v_pre && sp.spawn_ready;
      m_busy = (b_pre & ~release_mask) | (acc ? (NS'(1) << m_slot) : '0);
      m_ovf = 1'b0;
      if (!enable) m_pend = 0;
      else if (tick && !acc) begin
        if (p_pre == (1 << PB) - 1) m_ovf = 1'b1;
        else m_pend = p_pre + 1;
      end else if (acc && !tick && p_pre > 0) m_pend = p_pre - 1;
      if (m_ovf) n_ovf++;
      if (v_pre) begin
        m_valid = !acc;
        if (acc) begin
          m_last_acc = e;
          n_acc++;
        end
      end else begin
        rise = enable && (p_pre != 0) && (b_pre != '1) && (e - m_last_acc >= CD + 1);
        if (rise) begin
          m_slot = lowest_free(b_pre);
          m_x = xf(lfsr_prev);
        end
        m_valid = rise;
      end
      chk("rnd_valid", sp.spawn_valid, m_valid);
      chk("rnd_busy", busy_mask, m_busy);
      chk("rnd_pend", pending_cnt, m_pend);
      chk("rnd_ovf", overflow, m_ovf);
      if (m_valid) begin
        chk("rnd_slot", sp.spawn_slot, m_slot);
        chk("rnd_x", sp.spawn_x, m_x);
      end
    end

`ifdef SPAWN_STATS_EN
    sp.spawn_ready = 1'b0;
    enable = 1'b0;
    tick = 1'b0;
    release_mask = '0;
    cyc();
    chk("stat_spawn", spawn_count, n_acc % 65536);
    chk("stat_drop", drop_count, (n_ovf > 255) ? 255 : n_ovf);
`endif

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
